// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: FSM state encodings, MSP430 addressing-mode and opcode-class constants.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    FST_OP_REQ,
    FST_OP_WAIT,
    FST_EXT_REQ,
    FST_EXT_WAIT,
    FST_VALID
  } fetch_state_t;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  localparam logic [2:0] OP_JUMP    = 3'b001;
  localparam logic [3:0] OP_ILLEGAL = 4'b0000;
  localparam logic [3:0] REG_CG2    = 4'd3;
  localparam logic [3:0] REG_PC     = 4'd0;

endpackage

// File: rtl/instr_len.sv
// Combinational MSP430 instruction length decode: which extension words follow an opcode word.
// No state, zero latency; also usable by the decoder.
module instr_len
  import instr_fetch_pkg::*;
(
  input  logic [15:0] word,
  output logic        need_src,
  output logic        need_dst,
  output logic [1:0]  n_ext,
  output logic        illegal
);

  logic       is_jump;
  logic       fmt1;
  logic [3:0] rs;
  logic [1:0] as_mode;
  logic       unused_bw;

  // Byte/word select does not affect instruction length.
  assign unused_bw = word[6];

  always_comb begin
    illegal  = (word[15:12] == OP_ILLEGAL);
    is_jump  = (word[15:13] == OP_JUMP);
    fmt1     = (word[15:14] != 2'b00);
    rs       = fmt1 ? word[11:8] : word[3:0];
    as_mode  = word[5:4];
    need_src = 1'b0;
    need_dst = 1'b0;
    if (!illegal && !is_jump) begin
      // R3 is always a constant generator; R2 only for As=1x, which the rule below never selects.
      need_src = ((as_mode == AS_IDX) && (rs != REG_CG2)) ||
                 ((as_mode == AS_INC) && (rs == REG_PC));
      need_dst = fmt1 && word[7];
    end
    n_ext = {1'b0, need_src} + {1'b0, need_dst};
  end

endmodule

// File: rtl/instr_fetch.sv
// MSP430 fetch stage: reads opcode plus extension words from a 1-cycle ROM and presents one registered
// bundle; valid 2+2*n_ext cycles after OP_REQ, held stable with no ROM reads while instr_ready is low.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] MAB_out,
  output logic        rom_rd,
  input  logic [15:0] MDB_out,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic [15:0] src_ext,
  output logic [15:0] dst_ext,
  output logic [1:0]  n_ext,
  output logic [15:0] instr_pc,
  output logic        illegal,
  output logic [15:0] pc_out
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic         need_src_q;
  logic         src_taken;
  logic [1:0]   remain;

  logic         len_src;
  logic         unused_len_dst;
  logic [1:0]   len_n;
  logic         len_illegal;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  instr_len u_len (
    .word     (MDB_out),
    .need_src (len_src),
    .need_dst (unused_len_dst),
    .n_ext    (len_n),
    .illegal  (len_illegal)
  );

  assign rom_rd  = (state == FST_OP_REQ) || (state == FST_EXT_REQ);
  assign MAB_out = pc;
  assign pc_out  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FST_OP_REQ;
      pc          <= {RESET_PC[15:1], 1'b0};
      instr_valid <= 1'b0;
      instr_word  <= 16'h0000;
      src_ext     <= 16'h0000;
      dst_ext     <= 16'h0000;
      n_ext       <= 2'd0;
      illegal     <= 1'b0;
      instr_pc    <= 16'h0000;
      need_src_q  <= 1'b0;
      src_taken   <= 1'b0;
      remain      <= 2'd0;
    end else if (redirect) begin
      // Any read in flight is simply never captured; the restarted fetch overwrites the bundle.
      pc          <= {redirect_pc[15:1], 1'b0};
      instr_valid <= 1'b0;
      state       <= FST_OP_REQ;
    end else begin
      case (state)
        FST_OP_REQ: begin
          instr_pc <= pc;
          pc       <= pc + 16'd2;
          state    <= FST_OP_WAIT;
        end
        FST_OP_WAIT: begin
          instr_word <= MDB_out;
          src_ext    <= 16'h0000;
          dst_ext    <= 16'h0000;
          n_ext      <= len_n;
          illegal    <= len_illegal;
          need_src_q <= len_src;
          src_taken  <= 1'b0;
          remain     <= len_n;
          if (len_n == 2'd0) begin
            instr_valid <= 1'b1;
            state       <= FST_VALID;
          end else begin
            state <= FST_EXT_REQ;
          end
        end
        FST_EXT_REQ: begin
          pc    <= pc + 16'd2;
          state <= FST_EXT_WAIT;
        end
        FST_EXT_WAIT: begin
          // Source extension word always precedes the destination one in memory.
          if (need_src_q && !src_taken) begin
            src_ext   <= MDB_out;
            src_taken <= 1'b1;
          end else begin
            dst_ext <= MDB_out;
          end
          remain <= remain - 2'd1;
          if (remain == 2'd1) begin
            instr_valid <= 1'b1;
            state       <= FST_VALID;
          end else begin
            state <= FST_EXT_REQ;
          end
        end
        FST_VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FST_OP_REQ;
          end
        end
        default: state <= FST_OP_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a behavioural ROM/length model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MAB_out;
  logic        rom_rd;
  logic [15:0] MDB_out;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] src_ext;
  logic [15:0] dst_ext;
  logic [1:0]  n_ext;
  logic [15:0] instr_pc;
  logic        illegal;
  logic [15:0] pc_out;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [0:32767];

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) MDB_out <= rom[MAB_out[15:1]];

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .MAB_out     (MAB_out),
    .rom_rd      (rom_rd),
    .MDB_out     (MDB_out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .src_ext     (src_ext),
    .dst_ext     (dst_ext),
    .n_ext       (n_ext),
    .instr_pc    (instr_pc),
    .illegal     (illegal),
    .pc_out      (pc_out)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MSP430 length rules: which extension words an opcode word carries.
  function automatic void ref_len(input logic [15:0] w, output int n, output bit has_src);
    bit fmt1;
    logic [3:0] rs;
    logic [1:0] am;
    n = 0;
    has_src = 0;
    if (w[15:12] == 4'h0 || w[15:13] == 3'b001) return;
    fmt1 = (w[15:12] >= 4'h4);
    am   = w[5:4];
    rs   = fmt1 ? w[11:8] : w[3:0];
    if (am == 2'b01 && rs != 4'd3) has_src = 1;
    if (am == 2'b11 && rs == 4'd0) has_src = 1;
    n = int'(has_src) + int'(fmt1 && w[7]);
  endfunction

  function automatic logic [82:0] snapshot();
    return {instr_word, src_ext, dst_ext, n_ext, instr_pc, illegal, pc_out};
  endfunction

  // Called at a negedge where the fetch FSM should be issuing the opcode read at pc.
  task automatic fetch_check(input string tag, inout logic [15:0] pc, input int stall);
    logic [15:0] w, e1, e2, p1, p2, exp_src, exp_dst, exp_next;
    logic [82:0] snap;
    int n, cyc;
    bit hs;
    p1 = pc + 16'd2;
    p2 = p1 + 16'd2;
    w  = rom[pc[15:1]];
    e1 = rom[p1[15:1]];
    e2 = rom[p2[15:1]];
    ref_len(w, n, hs);
    exp_src  = hs ? e1 : 16'h0;
    exp_dst  = (n == 2) ? e2 : ((n == 1 && !hs) ? e1 : 16'h0);
    exp_next = pc + 16'(2 + 2 * n);
    chk({tag, "/rom_rd"}, rom_rd, 1'b1);
    chk({tag, "/mab"}, MAB_out, pc);
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/latency"}, cyc, 2 + 2 * n);
    chk({tag, "/word"}, instr_word, w);
    chk({tag, "/src_ext"}, src_ext, exp_src);
    chk({tag, "/dst_ext"}, dst_ext, exp_dst);
    chk({tag, "/n_ext"}, n_ext, n);
    chk({tag, "/instr_pc"}, instr_pc, pc);
    chk({tag, "/illegal"}, illegal, (w[15:12] == 4'h0));
    chk({tag, "/pc_out"}, pc_out, exp_next);
    snap = snapshot();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "/stall_valid"}, instr_valid, 1'b1);
      chk({tag, "/stall_rd"}, rom_rd, 1'b0);
      chk({tag, "/stall_bundle"}, snapshot(), snap);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pc = exp_next;
  endtask

  task automatic pulse_redirect(input logic [15:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    logic [15:0] pc;
    int cyc;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    instr_ready = 1'b0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h4505;
    rom[1] = 16'h4035; rom[2] = 16'h1234;
    rom[3] = 16'h4592; rom[4] = 16'h0010; rom[5] = 16'h0020;
    rom[6] = 16'h4315;
    rom[7] = 16'h4325;
    rom[8] = 16'h4505;
    rom[16'h7FFF] = 16'h4505;
    rom[16'h0040] = 16'h4592;

    repeat (3) @(negedge clk);
    chk("rst/valid", instr_valid, 1'b0);
    chk("rst/word", instr_word, 16'h0);
    chk("rst/src", src_ext, 16'h0);
    chk("rst/dst", dst_ext, 16'h0);
    chk("rst/n_ext", n_ext, 2'd0);
    chk("rst/illegal", illegal, 1'b0);
    chk("rst/instr_pc", instr_pc, 16'h0);
    chk("rst/pc_out", pc_out, 16'h0);
    rst = 1'b0;
    pc = 16'h0000;

    fetch_check("single", pc, 0);
    fetch_check("imm", pc, 0);
    fetch_check("two_ext", pc, 0);
    fetch_check("cg_as01", pc, 0);
    fetch_check("cg_as10", pc, 0);
    fetch_check("stall", pc, 5);

    pulse_redirect(16'hFFFF);
    pc = 16'hFFFE;
    fetch_check("wrap", pc, 0);
    chk("wrap/pc", pc, 16'h0000);
    fetch_check("after_wrap", pc, 0);

    // Redirect while the first extension word of 0x4592 is being captured.
    pulse_redirect(16'h0080);
    chk("redir/mab0", MAB_out, 16'h0080);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("redir/partial_valid", instr_valid, 1'b0);
    end
    pulse_redirect(16'h0101);
    chk("redir/valid", instr_valid, 1'b0);
    chk("redir/mab", MAB_out, 16'h0100);
    chk("redir/rd", rom_rd, 1'b1);
    pc = 16'h0100;
    fetch_check("after_redir", pc, 0);

    // Redirect together with ready in VALID must take the redirect target.
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("redir_rdy/reached_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    pulse_redirect(16'h0200);
    instr_ready = 1'b0;
    chk("redir_rdy/valid", instr_valid, 1'b0);
    chk("redir_rdy/mab", MAB_out, 16'h0200);
    chk("redir_rdy/rd", rom_rd, 1'b1);
    pc = 16'h0200;
    fetch_check("after_redir_rdy", pc, 0);

    // Reset in the middle of a fetch.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst/valid", instr_valid, 1'b0);
    chk("mid_rst/word", instr_word, 16'h0);
    chk("mid_rst/n_ext", n_ext, 2'd0);
    chk("mid_rst/pc_out", pc_out, 16'h0);
    chk("mid_rst/rd", rom_rd, 1'b1);
    rst = 1'b0;
    pc = 16'h0000;
    fetch_check("post_rst", pc, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] tgt;
        tgt = 16'($urandom);
        pulse_redirect(tgt);
        pc = {tgt[15:1], 1'b0};
      end
      fetch_check("rnd", pc, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
